// File: rtl/cla_seq_pkg.sv
// Shared definitions for the slice-serial carry-look-ahead adder.
package cla_seq_pkg;

  // Width of one carry-look-ahead slice; the datapath processes one slice per cycle.
  localparam int SLICE_W = 4;

  // Controller states: waiting for work, stepping through slices, holding a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : cla_seq_pkg

// File: rtl/cla4_unit.sv
// Combinational 4-bit carry-look-ahead slice: all internal carries are
// produced directly from generate/propagate terms instead of rippling.
module cla4_unit
  import cla_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);

  logic [SLICE_W-1:0] w_p;
  logic [SLICE_W-1:0] w_g;
  logic [SLICE_W:0]   w_c;

  // Per-bit propagate/generate and the final sum bits.
  generate
    for (genvar gi = 0; gi < SLICE_W; gi++) begin : g_bit
      assign w_p[gi] = a[gi] ^ b[gi];
      assign w_g[gi] = a[gi] & b[gi];
      assign s[gi]   = w_p[gi] ^ w_c[gi];
    end
  endgenerate

  // Flattened look-ahead carry equations.
  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

  assign cout = w_c[4];

endmodule : cla4_unit

// File: rtl/cla_seq_adder.sv
// Slice-serial adder/subtractor: one 4-bit CLA slice is reused over
// WIDTH/4 cycles, with the inter-slice carry held in a register.
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;
  logic [SLICE_W-1:0] r_sum_sl [NSLICE];
  logic               r_cout;
  logic               r_ovf;
  logic               r_zero;

  logic [SLICE_W-1:0] w_a_sl [NSLICE];
  logic [SLICE_W-1:0] w_b_sl [NSLICE];
  logic [NSLICE-1:0]  w_sum_nz;
  logic [SLICE_W-1:0] w_a_cur;
  logic [SLICE_W-1:0] w_b_cur;
  logic [SLICE_W-1:0] w_s;
  logic               w_cout;
  logic               w_c_msb;
  logic               w_lower_zero;

  // Split operands and result into slice views; result slices drive out_sum directly.
  generate
    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
      assign w_a_sl[gi] = r_a[gi*SLICE_W +: SLICE_W];
      assign w_b_sl[gi] = r_b[gi*SLICE_W +: SLICE_W];
      assign w_sum_nz[gi] = |r_sum_sl[gi];
      assign out_sum[gi*SLICE_W +: SLICE_W] = r_sum_sl[gi];
    end
  endgenerate

  assign w_a_cur = w_a_sl[r_idx];
  assign w_b_cur = w_b_sl[r_idx];

  // The single shared slice; carry enters only from the carry register.
  cla4_unit u_cla4 (
    .a    (w_a_cur),
    .b    (w_b_cur),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_cout)
  );

  // Carry into the top bit recovered from the top sum bit: s = a ^ b ^ c.
  assign w_c_msb = w_s[SLICE_W-1] ^ w_a_cur[SLICE_W-1] ^ w_b_cur[SLICE_W-1];

  // On the last slice every lower slice of the result is already stored.
  assign w_lower_zero = ~|w_sum_nz[NSLICE-2:0];

  // Handshake and status flags decode straight from the state register.
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign out_cout  = r_cout;
  assign out_ovf   = r_ovf;
  assign out_zero  = r_zero;

  // Controller and datapath: accept, step one slice per cycle, hold until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
      for (int i = 0; i < NSLICE; i++) begin
        r_sum_sl[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= in_a;
            // Subtract is A + ~B + 1; the +1 rides in as the initial carry.
            r_b     <= in_sub ? ~in_b : in_b;
            r_carry <= in_sub | in_cin;
            r_idx   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_sum_sl[r_idx] <= w_s;
          r_carry         <= w_cout;
          r_idx           <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            r_cout  <= w_cout;
            r_ovf   <= w_c_msb ^ w_cout;
            r_zero  <= w_lower_zero & ~|w_s;
            r_idx   <= '0;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule : cla_seq_adder

// File: tb/tb_cla_seq_adder.sv
// Scoreboard bench for cla_seq_adder at WIDTH=16.
module tb_cla_seq_adder;

  localparam int WIDTH  = 16;
  localparam int NSLICE = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_cin = 1'b0;
  logic             in_sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;
  logic             busy;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  cla_seq_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 17-bit arithmetic, overflow from operand/result signs.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] bb;
    exp_t             e;
    bb     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, bb} + (WIDTH+1)'(sub ? 1'b1 : cin);
    e.sum  = full[WIDTH-1:0];
    e.cout = full[WIDTH];
    e.ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    e.zero = (full[WIDTH-1:0] == '0);
    return e;
  endfunction

  // Compare every consumed result against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_nonempty", 32'(sb_q.size()), 1);
      end else begin
        e = sb_q.pop_front();
        check_eq("sum", out_sum, e.sum);
        check_eq("cout", out_cout, e.cout);
        check_eq("ovf", out_ovf, e.ovf);
        check_eq("zero", out_zero, e.zero);
        $display("result sum=0x%04h cout=%0b ovf=%0b zero=%0b", out_sum, out_cout, out_ovf, out_zero);
      end
    end
  end

  // Present an operation, wait for acceptance, push its expectation.
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input logic sub);
    int guard;
    guard = 0;
    @(negedge clk);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check_eq("accept_timeout", 32'(guard), 0);
    sb_q.push_back(model(a, b, cin, sub));
    $display("op a=0x%04h b=0x%04h cin=%0b sub=%0b", a, b, cin, sub);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = WIDTH'($urandom); in_b = WIDTH'($urandom);
    in_cin = 1'($urandom); in_sub = 1'($urandom);
  endtask

  // Called #1 after the accepting edge; counts edges until out_valid.
  task automatic wait_result();
    int cnt;
    cnt = 0;
    check_eq("busy_run", busy, 1);
    while (!out_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    check_eq("latency", 32'(cnt), NSLICE);
  endtask

  // Stall for a few cycles with outputs checked stable, then consume.
  task automatic consume(input int stall);
    logic [WIDTH-1:0] s_sum;
    logic [2:0]       s_flags;
    s_sum   = out_sum;
    s_flags = {out_cout, out_ovf, out_zero};
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_sum", out_sum, s_sum);
      check_eq("hold_flags", {out_cout, out_ovf, out_zero}, s_flags);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("idle_valid", out_valid, 0);
    check_eq("idle_ready", in_ready, 1);
  endtask

  task automatic full_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic sub, input int stall);
    start_op(a, b, cin, sub);
    wait_result();
    consume(stall);
  endtask

  logic [WIDTH-1:0] dir_a [7] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h0000, 16'h8000, 16'hFFFF};
  logic [WIDTH-1:0] dir_b [7] = '{16'h4321, 16'h0001, 16'h0001, 16'h0007, 16'h0000, 16'h0001, 16'hFFFF};
  logic             dir_c [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic             dir_s [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    logic [WIDTH-1:0] s_sum;
    int               seen;

    // Reset state
    #3 rst_n = 1'b0;
    #1;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_sum", out_sum, 0);
    check_eq("rst_flags", {out_cout, out_ovf, out_zero}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases
    for (int i = 0; i < 7; i++) begin
      full_op(dir_a[i], dir_b[i], dir_c[i], dir_s[i], i % 3);
    end

    // Back-pressure with a second operation waiting
    start_op(16'h00F0, 16'h0F0F, 1'b1, 1'b0);
    wait_result();
    s_sum = out_sum;
    @(negedge clk);
    in_a = 16'hA5A5; in_b = 16'h5A5A; in_cin = 1'b0; in_sub = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_eq("bp_in_ready", in_ready, 0);
      check_eq("bp_valid", out_valid, 1);
      check_eq("bp_sum", out_sum, s_sum);
    end
    @(negedge clk);
    out_ready = 1'b1;
    sb_q.push_back(model(16'hA5A5, 16'h5A5A, 1'b0, 1'b1));
    $display("op a=0x%04h b=0x%04h cin=%0b sub=%0b", 16'hA5A5, 16'h5A5A, 1'b0, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("bp_no_same_cycle_accept", busy, 0);
    check_eq("bp_ready_after", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result();
    consume(1);

    // Reset two cycles into RUN
    start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ready", in_ready, 1);
    check_eq("mid_rst_valid", out_valid, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_sum", out_sum, 0);
    check_eq("mid_rst_flags", {out_cout, out_ovf, out_zero}, 0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    check_eq("no_result_after_rst", 32'(seen), 0);
    full_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 0);

    // Random operations
    for (int i = 0; i < 12; i++) begin
      full_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom),
              int'($urandom_range(0, 2)));
    end

    check_eq("sb_drained", 32'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_cla_seq_adder

// File: doc/cla_seq_adder.md
CLA_SEQ_ADDER -- requirements
Module: cla_seq_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 Derived constant NSLICE = WIDTH/4: number of 4-bit slices per operation.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  requester has an operation pending.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 in_a  input  WIDTH  operand A.
REQ-008 in_b  input  WIDTH  operand B.
REQ-009 in_cin  input  1  carry-in; used for add only.
REQ-010 in_sub  input  1  0 selects A+B+cin; 1 selects A-B, computed as A+~B+1 with in_cin ignored.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 out_sum  output  WIDTH  result.
REQ-014 out_cout  output  1  carry out of the MSB slice; for subtract, 1 means no borrow.
REQ-015 out_ovf  output  1  signed overflow: carry into the MSB XOR carry out of the MSB.
REQ-016 out_zero  output  1  out_sum == 0.
REQ-017 busy  output  1  asserted in RUN and in DONE.

Function
REQ-018 The FSM SHALL have the states IDLE, RUN and DONE; all outputs SHALL be driven from registers or decoded from the state.
REQ-019 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-020 In IDLE, when in_valid and in_ready are both 1:
- latch A and B, or ~B if in_sub;
- set carry register = in_sub ? 1 : in_cin;
- set slice index = 0;
- move to RUN.
REQ-021 In RUN, each cycle SHALL process exactly one slice, least-significant first:
- apply slice[idx] of A and B plus the carry register to the 4-bit CLA slice;
- write the 4-bit sum into out_sum[4*idx+3:4*idx];
- carry register <= slice cout;
- idx <= idx+1.
REQ-022 When idx == NSLICE-1, the RUN cycle SHALL also latch out_cout, compute out_ovf (carry into bit WIDTH-1 XOR slice cout) and out_zero, then move to DONE.
REQ-023 Latency: if acceptance occurs at clock edge T, out_valid SHALL be 1 after edge T+NSLICE (after T+4 for WIDTH=16).
REQ-024 In DONE, out_sum, out_cout, out_ovf and out_zero SHALL hold stable until out_valid and out_ready are both 1 at a clock edge; the FSM then moves to IDLE.
REQ-025 A new operation SHALL NOT be accepted in the same cycle a result is consumed; minimum spacing between accepts is NSLICE+2 cycles.
REQ-026 in_valid asserted while busy SHALL be ignored, with no state change; the requester SHALL hold it until in_ready.
REQ-027 out_sum content during RUN is unspecified to the consumer; only its value while out_valid is 1 is defined.
REQ-028 Carry SHALL propagate across slices only through the carry register; no combinational path SHALL exist from in_* to out_*.

Reset
REQ-029 While rst_n is 0, the FSM SHALL be in IDLE.
REQ-030 While rst_n is 0, out_sum, out_cout, out_ovf, out_zero, out_valid, busy, idx and the carry register SHALL be 0, and in_ready SHALL be 1.
REQ-031 Reset asserted mid-RUN or mid-DONE SHALL abandon the operation immediately; no result SHALL be emitted for it.

Structure
REQ-032 The shared package cla_seq_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the localparam SLICE_W = 4.
REQ-033 The single sub-module cla4_unit (combinational 4-bit carry-look-ahead slice: a, b, cin -> s, cout) SHALL be instantiated once and time-shared across all slices.

Verification (WIDTH=16)
REQ-034 Add 0x1234 + 0x4321, cin=0 -> out_sum=0x5555, out_cout=0, out_ovf=0, out_zero=0, with out_valid 4 cycles after accept.
REQ-035 Add 0xFFFF + 0x0001 -> out_sum=0x0000, out_cout=1, out_zero=1, out_ovf=0; this exercises carry through every slice.
REQ-036 Add 0x7FFF + 0x0001 -> out_sum=0x8000, out_ovf=1, out_cout=0; subtract 0x0005 - 0x0007 -> out_sum=0xFFFE, out_cout=0, out_ovf=0.
REQ-037 Hold out_ready=0 for 3 cycles in DONE while in_valid=1 with a second operation -> outputs stable, in_ready=0; the second operation is accepted only after the first is consumed and the FSM is back in IDLE.
REQ-038 Assert rst_n=0 two cycles into RUN -> all outputs 0 and in_ready=1 during reset; no out_valid afterward; the next operation completes correctly.
